// File: rtl/vblank_access_arbiter_pkg.sv
// Shared raster geometry and FSM encoding for the vblank access arbiter.
package vblank_access_arbiter_pkg;

    localparam int H_TOTAL        = 768;
    localparam int V_TOTAL        = 512;
    localparam int V_ACTIVE_LINES = 480;
    localparam int IDX_W          = 3;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_ARB    = 2'd1,
        ST_GRANT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vblank_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping.
module vblank_access_arbiter_rr_pick
    import vblank_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int best;

    // Pick the requester with the smallest wrapped distance from ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        onehot = '0;
        idx    = '0;
        best   = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && ((j - int'(ptr) + NUM_REQ) % NUM_REQ) < best) begin
                best      = (j - int'(ptr) + NUM_REQ) % NUM_REQ;
                idx       = IDX_W'(j);
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        end
        valid = (best < NUM_REQ);
    end

endmodule

// File: rtl/vblank_access_arbiter.sv
// Grants the shared memory write port to one requester at a time, only during vertical blanking.
module vblank_access_arbiter
    import vblank_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int V_ACTIVE    = V_ACTIVE_LINES,
    parameter int GUARD_LINES = 2,
    parameter int X_MAX       = H_TOTAL - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         counter_x,
    input  logic [8:0]         counter_y,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               frame_tick,
    output logic               vblank,
    output logic               overrun,
    output logic [IDX_W-1:0]   overrun_id
);

    localparam logic [8:0] FIRST_BLANK = 9'(V_ACTIVE);
    localparam logic [8:0] GUARD_Y     = 9'(V_TOTAL - GUARD_LINES);
    localparam logic [8:0] LAST_LINE   = 9'(V_TOTAL - 1);
    localparam logic [9:0] LAST_X      = 10'(X_MAX);

    arb_state_t         state, state_nx;
    logic [NUM_REQ-1:0] grant_nx, pick_onehot;
    logic [IDX_W-1:0]   gidx, gidx_nx, rr_ptr, rr_ptr_nx, overrun_id_nx, pick_idx;
    logic               overrun_nx, pick_valid;
    logic               tick_hit, window_open, forced_end, release_g;

    assign tick_hit   = (counter_y == FIRST_BLANK) && (counter_x == 10'd0);
    assign forced_end = (counter_y == LAST_LINE) && (counter_x == LAST_X);
    assign release_g  = (|(grant & done)) || !(|(grant & req));

    // The line-range test keeps the stale vblank flag at (0,0) from reopening the window.
    assign window_open = vblank && (counter_y >= FIRST_BLANK) && (counter_y < GUARD_Y);

    vblank_access_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        gidx_nx       = gidx;
        rr_ptr_nx     = rr_ptr;
        overrun_nx    = 1'b0;
        overrun_id_nx = overrun_id;
        case (state)
            ST_ACTIVE: begin
                grant_nx = '0;
                if (tick_hit) state_nx = ST_ARB;
            end
            ST_ARB: begin
                if (!window_open) begin
                    state_nx = ST_ACTIVE;
                end else if (pick_valid) begin
                    grant_nx = pick_onehot;
                    gidx_nx  = pick_idx;
                    state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A release in the last cycle of the frame wins over the forced revoke.
                if (release_g) begin
                    grant_nx  = '0;
                    rr_ptr_nx = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
                    state_nx  = ST_ARB;
                end else if (forced_end) begin
                    grant_nx      = '0;
                    overrun_nx    = 1'b1;
                    overrun_id_nx = gidx;
                    rr_ptr_nx     = gidx;
                    state_nx      = ST_ACTIVE;
                end
            end
            default: begin
                grant_nx = '0;
                state_nx = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACTIVE;
            grant      <= '0;
            gidx       <= '0;
            rr_ptr     <= '0;
            overrun    <= 1'b0;
            overrun_id <= '0;
            vblank     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nx;
            grant      <= grant_nx;
            gidx       <= gidx_nx;
            rr_ptr     <= rr_ptr_nx;
            overrun    <= overrun_nx;
            overrun_id <= overrun_id_nx;
            vblank     <= (counter_y >= FIRST_BLANK);
            frame_tick <= tick_hit;
        end
    end

endmodule

// File: tb/tb_vblank_access_arbiter.sv
// Directed self-checking bench for vblank_access_arbiter; counters are driven directly so scenarios can jump in the raster.
module tb_vblank_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] counter_x = '0;
    logic [8:0] counter_y = '0;
    logic [2:0] req = '0;
    logic [2:0] done = '0;
    logic [2:0] grant;
    logic       frame_tick;
    logic       vblank;
    logic       overrun;
    logic [2:0] overrun_id;

    int n_assert = 0;
    int n_fail   = 0;

    vblank_access_arbiter #(
        .NUM_REQ(3), .V_ACTIVE(480), .GUARD_LINES(2), .X_MAX(767)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .frame_tick (frame_tick),
        .vblank     (vblank),
        .overrun    (overrun),
        .overrun_id (overrun_id)
    );

    always #5 clk = ~clk;

    // One clock: outputs afterwards reflect the counter position held before the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (counter_x == 10'd767) begin
            counter_x = '0;
            counter_y = counter_y + 9'd1;
        end else begin
            counter_x = counter_x + 10'd1;
        end
    endtask

    task automatic set_pos(input int y, input int x);
        counter_y = 9'(y);
        counter_x = 10'(x);
    endtask

    task automatic do_reset();
        req   = '0;
        done  = '0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_pos(480, 0);
        req = 3'b111;
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_assert++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        n_assert++; if (vblank !== 1'b0) begin n_fail++; $display("FAIL reset_vblank: got %b want 0", vblank); end
        n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_assert++; if (overrun_id !== 3'd0) begin n_fail++; $display("FAIL reset_overrun_id: got %0d want 0", overrun_id); end
        req   = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_frame_timing();
        int  py, px;
        logic exp_tick, exp_vb;
        set_pos(479, 765);
        for (int i = 0; i < 6; i++) begin
            py = int'(counter_y);
            px = int'(counter_x);
            cyc();
            exp_tick = (py == 480 && px == 0);
            exp_vb   = (py >= 480);
            n_assert++; if (frame_tick !== exp_tick) begin n_fail++; $display("FAIL tick_rise@%0d,%0d: got %b want %b", py, px, frame_tick, exp_tick); end
            n_assert++; if (vblank !== exp_vb) begin n_fail++; $display("FAIL vblank_rise@%0d,%0d: got %b want %b", py, px, vblank, exp_vb); end
            n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL idle_grant@%0d,%0d: got %b want 000", py, px, grant); end
        end
        set_pos(511, 765);
        for (int i = 0; i < 5; i++) begin
            py = int'(counter_y);
            px = int'(counter_x);
            cyc();
            exp_vb = (py >= 480);
            n_assert++; if (vblank !== exp_vb) begin n_fail++; $display("FAIL vblank_fall@%0d,%0d: got %b want %b", py, px, vblank, exp_vb); end
            n_assert++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_quiet@%0d,%0d: got %b want 0", py, px, frame_tick); end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        do_reset();
        req = 3'b111;
        set_pos(480, 0);
        cyc();
        n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rr_no_early_grant: got %b want 000", grant); end
        cyc();
        for (int n = 0; n < 4; n++) begin
            exp = 3'(1 << (n % 3));
            for (int c = 0; c < 11; c++) begin
                n_assert++; if (grant !== exp) begin n_fail++; $display("FAIL rr_hold n=%0d c=%0d: got %b want %b", n, c, grant, exp); end
                if (c == 10) done = exp;
                cyc();
                done = '0;
            end
            n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rr_dead n=%0d: got %b want 000", n, grant); end
            cyc();
        end
        req = '0;
    endtask

    task automatic test_overrun();
        do_reset();
        req = 3'b010;
        set_pos(480, 0);
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b010) begin n_fail++; $display("FAIL ovr_grant: got %b want 010", grant); end
        set_pos(511, 765);
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b010 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: grant %b overrun %b want 010 0", grant, overrun); end
        cyc();
        n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL ovr_revoke: got %b want 000", grant); end
        n_assert++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        n_assert++; if (overrun_id !== 3'd1) begin n_fail++; $display("FAIL ovr_id: got %0d want 1", overrun_id); end
        cyc();
        n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
        n_assert++; if (overrun_id !== 3'd1) begin n_fail++; $display("FAIL ovr_id_sticky: got %0d want 1", overrun_id); end
        req = 3'b011;
        set_pos(480, 0);
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b010) begin n_fail++; $display("FAIL ovr_priority: got %b want 010", grant); end
        done = 3'b010;
        cyc();
        done = '0;
        n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL ovr_release: got %b want 000", grant); end
        cyc();
        n_assert++; if (grant !== 3'b001) begin n_fail++; $display("FAIL ovr_next: got %b want 001", grant); end
        req = '0;
    endtask

    task automatic test_guard();
        do_reset();
        set_pos(480, 0);
        cyc();
        cyc();
        set_pos(510, 0);
        req = 3'b100;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL guard_line510 i=%0d: got %b want 000", i, grant); end
        end
        set_pos(511, 766);
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL guard_wrap i=%0d: got %b want 000", i, grant); end
        end
        set_pos(480, 0);
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b100) begin n_fail++; $display("FAIL guard_next_frame: got %b want 100", grant); end
        req = '0;
    endtask

    task automatic test_done_ignore();
        do_reset();
        req = 3'b001;
        set_pos(480, 0);
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b001) begin n_fail++; $display("FAIL ign_grant: got %b want 001", grant); end
        done = 3'b100;
        cyc();
        done = '0;
        n_assert++; if (grant !== 3'b001) begin n_fail++; $display("FAIL ign_foreign_done: got %b want 001", grant); end
        set_pos(511, 766);
        cyc();
        n_assert++; if (grant !== 3'b001) begin n_fail++; $display("FAIL ign_hold: got %b want 001", grant); end
        done = 3'b001;
        cyc();
        done = '0;
        n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL last_cycle_release: got %b want 000", grant); end
        n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL last_cycle_no_overrun: got %b want 0", overrun); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_assert++; if (grant !== 3'b000 || overrun !== 1'b0) begin n_fail++; $display("FAIL no_grant_in_active i=%0d: grant %b overrun %b want 000 0", i, grant, overrun); end
        end
        n_assert++; if (overrun_id !== 3'd0) begin n_fail++; $display("FAIL last_cycle_id: got %0d want 0", overrun_id); end
        req = '0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 3'b110;
        set_pos(480, 0);
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rst_first: got %b want 010", grant); end
        done = 3'b010;
        cyc();
        done = '0;
        cyc();
        n_assert++; if (grant !== 3'b100) begin n_fail++; $display("FAIL rst_second: got %b want 100", grant); end
        rst_n = 1'b0;
        #1;
        n_assert++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rst_async_grant: got %b want 000", grant); end
        n_assert++; if (vblank !== 1'b0) begin n_fail++; $display("FAIL rst_async_vblank: got %b want 0", vblank); end
        n_assert++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst_async_tick: got %b want 0", frame_tick); end
        cyc();
        cyc();
        cyc();
        n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_no_overrun: got %b want 0", overrun); end
        rst_n = 1'b1;
        req = 3'b111;
        set_pos(480, 0);
        cyc();
        cyc();
        n_assert++; if (grant !== 3'b001) begin n_fail++; $display("FAIL rst_ptr_cleared: got %b want 001", grant); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_round_robin();
        test_overrun();
        test_guard();
        test_done_ignore();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
